// File: rtl/i2c_bit_engine.sv
// I2C bit-level engine: runs START/WRITE0/WRITE1/READ/STOP as four programmable quarter-periods
// with clock stretching, arbitration detection and bus hold. Optional macro: I2C_STRETCH_TIMEOUT_EN.
module i2c_bit_engine #(
    parameter int PRESC_W     = 24,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH_MAX = 65535
) (
    input  logic               clock,
    input  logic               rst,
    input  logic [PRESC_W-1:0] presc,
    input  logic               cmd_vld,
    input  logic [2:0]         cmd,
    output logic               cmd_ready,
    output logic               rsp_vld,
    output logic               rsp_data,
    output logic               rsp_arb_lost,
    output logic               rsp_timeout,
    output logic               busy,
    input  logic               scl_i,
    input  logic               sda_i,
    output logic               scl_o,
    output logic               scl_t,
    output logic               sda_o,
    output logic               sda_t
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_Q0   = 3'd1,
        ST_Q1W  = 3'd2,
        ST_Q1   = 3'd3,
        ST_Q2   = 3'd4,
        ST_Q3   = 3'd5,
        ST_RSP  = 3'd6
    } state_t;

    localparam logic [2:0] CMD_START = 3'd1;
    localparam logic [2:0] CMD_WR1   = 3'd2;
    localparam logic [2:0] CMD_WR0   = 3'd3;
    localparam logic [2:0] CMD_STOP  = 3'd4;
    localparam logic [2:0] CMD_READ  = 3'd5;

    // Release pattern {scl_rel, sda_rel} of a phase; a repeated START keeps SCL low in Q0.
    function automatic logic [1:0] phase_lines(input logic [2:0] c, input state_t ph, input logic held);
        logic [1:0] r;
        r = 2'b11;
        case (c)
            CMD_START: begin
                case (ph)
                    ST_Q0:        r = {~held, 1'b1};
                    ST_Q1W, ST_Q1: r = 2'b11;
                    ST_Q2:        r = 2'b10;
                    ST_Q3:        r = 2'b00;
                    default:      r = 2'b11;
                endcase
            end
            CMD_WR1, CMD_READ: begin
                case (ph)
                    ST_Q0, ST_Q3:         r = 2'b01;
                    ST_Q1W, ST_Q1, ST_Q2: r = 2'b11;
                    default:              r = 2'b11;
                endcase
            end
            CMD_WR0: begin
                case (ph)
                    ST_Q0, ST_Q3:         r = 2'b00;
                    ST_Q1W, ST_Q1, ST_Q2: r = 2'b10;
                    default:              r = 2'b11;
                endcase
            end
            CMD_STOP: begin
                case (ph)
                    ST_Q0:         r = 2'b00;
                    ST_Q1W, ST_Q1: r = 2'b10;
                    ST_Q2, ST_Q3:  r = 2'b11;
                    default:       r = 2'b11;
                endcase
            end
            default: r = 2'b11;
        endcase
        return r;
    endfunction

    state_t             state_r, state_s;
    logic [PRESC_W-1:0] cnt_r, cnt_s, presc_r, presc_s;
    logic [2:0]         cmd_r, cmd_s;
    logic               busy_r, busy_s, rd_r, rd_s;
    logic [1:0]         lines_s;
    logic               scl_o_r, scl_t_r, sda_o_r, sda_t_r;
    logic               cmd_ready_r, rsp_vld_r, rsp_data_r, rsp_arb_r;
    logic               rsp_data_s, arb_lost_s;
    logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r, rel_hist_r;
    logic               scl_sync_s, sda_sync_s, phase_done_s, arb_s;

`ifdef I2C_STRETCH_TIMEOUT_EN
    localparam int               STC_W    = $clog2(STRETCH_MAX + 1);
    localparam logic [STC_W-1:0] STC_LAST = STC_W'(STRETCH_MAX - 1);
    logic [STC_W-1:0] stc_r, stc_s;
    logic             timeout_s, rsp_to_r;
`endif

    assign scl_sync_s   = scl_sync_r[SYNC_STAGES-1];
    assign sda_sync_s   = sda_sync_r[SYNC_STAGES-1];
    assign phase_done_s = (cnt_r == presc_r);
    // rel_hist_r ensures the synchronised SDA already reflects our own release before judging it.
    assign arb_s = (cmd_r != CMD_READ) && sda_o_r && (&rel_hist_r) && scl_sync_s && !sda_sync_s;

    // Pad input synchronisers plus history of our own SDA release aligned to them.
    always_ff @(posedge clock) begin
        if (rst) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
            rel_hist_r <= {SYNC_STAGES{1'b1}};
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
            rel_hist_r <= {rel_hist_r[SYNC_STAGES-2:0], sda_o_r};
        end
    end

    // Next-state, phase counter, line values and response flags.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        presc_s    = presc_r;
        cmd_s      = cmd_r;
        busy_s     = busy_r;
        rd_s       = rd_r;
        lines_s    = {scl_o_r, sda_o_r};
        rsp_data_s = 1'b0;
        arb_lost_s = 1'b0;
`ifdef I2C_STRETCH_TIMEOUT_EN
        stc_s      = stc_r;
        timeout_s  = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (cmd_vld && cmd_ready_r) begin
                    cmd_s   = cmd;
                    presc_s = presc;
                    cnt_s   = {PRESC_W{1'b0}};
                    if (cmd >= CMD_START && cmd <= CMD_READ) begin
                        state_s = ST_Q0;
                        lines_s = phase_lines(cmd, ST_Q0, busy_r);
                    end else begin
                        state_s = ST_RSP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_Q0: begin
                if (phase_done_s) begin
                    state_s = ST_Q1W;
                    lines_s = phase_lines(cmd_r, ST_Q1W, busy_r);
`ifdef I2C_STRETCH_TIMEOUT_EN
                    stc_s   = {STC_W{1'b0}};
`endif
                end else begin
                    cnt_s = cnt_r + PRESC_W'(1);
                end
            end
            ST_Q1W: begin
                if (scl_sync_s) begin
                    state_s = ST_Q1;
                    cnt_s   = {PRESC_W{1'b0}};
                    lines_s = phase_lines(cmd_r, ST_Q1, busy_r);
                end
`ifdef I2C_STRETCH_TIMEOUT_EN
                else if (stc_r == STC_LAST) begin
                    state_s   = ST_RSP;
                    lines_s   = 2'b11;
                    busy_s    = 1'b0;
                    timeout_s = 1'b1;
                end else begin
                    stc_s = stc_r + STC_W'(1);
                end
`else
                else begin
                    state_s = ST_Q1W;
                end
`endif
            end
            ST_Q1: begin
                if (arb_s) begin
                    state_s    = ST_RSP;
                    lines_s    = 2'b11;
                    busy_s     = 1'b0;
                    arb_lost_s = 1'b1;
                end else if (phase_done_s) begin
                    state_s = ST_Q2;
                    cnt_s   = {PRESC_W{1'b0}};
                    lines_s = phase_lines(cmd_r, ST_Q2, busy_r);
                    rd_s    = sda_sync_s;
                end else begin
                    cnt_s = cnt_r + PRESC_W'(1);
                end
            end
            ST_Q2: begin
                if (arb_s) begin
                    state_s    = ST_RSP;
                    lines_s    = 2'b11;
                    busy_s     = 1'b0;
                    arb_lost_s = 1'b1;
                end else if (phase_done_s) begin
                    state_s = ST_Q3;
                    cnt_s   = {PRESC_W{1'b0}};
                    lines_s = phase_lines(cmd_r, ST_Q3, busy_r);
                end else begin
                    cnt_s = cnt_r + PRESC_W'(1);
                end
            end
            ST_Q3: begin
                if (phase_done_s) begin
                    state_s    = ST_RSP;
                    busy_s     = (cmd_r != CMD_STOP);
                    rsp_data_s = (cmd_r == CMD_READ) ? rd_r : 1'b0;
                end else begin
                    cnt_s = cnt_r + PRESC_W'(1);
                end
            end
            ST_RSP:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {PRESC_W{1'b0}};
            presc_r     <= {PRESC_W{1'b0}};
            cmd_r       <= 3'd0;
            busy_r      <= 1'b0;
            rd_r        <= 1'b0;
            scl_o_r     <= 1'b1;
            scl_t_r     <= 1'b0;
            sda_o_r     <= 1'b1;
            sda_t_r     <= 1'b0;
            cmd_ready_r <= 1'b0;
            rsp_vld_r   <= 1'b0;
            rsp_data_r  <= 1'b0;
            rsp_arb_r   <= 1'b0;
`ifdef I2C_STRETCH_TIMEOUT_EN
            stc_r       <= {STC_W{1'b0}};
            rsp_to_r    <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            presc_r     <= presc_s;
            cmd_r       <= cmd_s;
            busy_r      <= busy_s;
            rd_r        <= rd_s;
            scl_o_r     <= lines_s[1];
            scl_t_r     <= ~lines_s[1];
            sda_o_r     <= lines_s[0];
            sda_t_r     <= ~lines_s[0];
            cmd_ready_r <= (state_s == ST_IDLE);
            rsp_vld_r   <= (state_s == ST_RSP);
            rsp_data_r  <= rsp_data_s;
            rsp_arb_r   <= arb_lost_s;
`ifdef I2C_STRETCH_TIMEOUT_EN
            stc_r       <= stc_s;
            rsp_to_r    <= timeout_s;
`endif
        end
    end

    assign cmd_ready    = cmd_ready_r;
    assign rsp_vld      = rsp_vld_r;
    assign rsp_data     = rsp_data_r;
    assign rsp_arb_lost = rsp_arb_r;
    assign busy         = busy_r;
    assign scl_o        = scl_o_r;
    assign scl_t        = scl_t_r;
    assign sda_o        = sda_o_r;
    assign sda_t        = sda_t_r;
`ifdef I2C_STRETCH_TIMEOUT_EN
    assign rsp_timeout  = rsp_to_r;
`else
    assign rsp_timeout  = 1'b0;
`endif

endmodule
